// File: rtl/pwm_fader_pkg.sv
// Shared types for the PWM fader: command modes, controller states and field widths.
package pwm_fader_pkg;

  typedef enum logic [1:0] {
    ModeOff     = 2'd0,
    ModeSet     = 2'd1,
    ModeFade    = 2'd2,
    ModeBreathe = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StFade,
    StBrthUp,
    StBrthDn
  } state_e;

  localparam int unsigned RateW = 8;

endpackage

// File: rtl/pwm_fader_if.sv
// Command handshake bundle between a command source and the PWM fader.
interface pwm_fader_if #(
  parameter int unsigned N = 8
) ();
  import pwm_fader_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  mode_e            cmd_mode;
  logic [N-1:0]     cmd_target;
  logic [RateW-1:0] cmd_rate;

  modport master (
    output cmd_valid,
    output cmd_mode,
    output cmd_target,
    output cmd_rate,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_mode,
    input  cmd_target,
    input  cmd_rate,
    output cmd_ready
  );

endinterface

// File: rtl/tick_gen.sv
// Reusable prescaler: one-cycle tick every period+1 enabled clocks, cleared while disabled.
module tick_gen #(
  parameter int unsigned PW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic [PW-1:0] period,
  output logic          tick
);

  logic [PW-1:0] cnt_q;
  logic          tick_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (!ena) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q >= period) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      tick_q <= 1'b0;
    end
  end

  // Gate with ena so the tick drops in the same cycle the block is disabled.
  assign tick = tick_q & ena;

endmodule

// File: rtl/pwm_fader.sv
// Duty-cycle sequencer for a PWM: set, linear fade to target, or continuous breathe.
module pwm_fader
  import pwm_fader_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned PW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [PW-1:0] prescale,
  pwm_fader_if.slave    cmd,
  output logic          step,
  output logic [N-1:0]  duty,
  output logic          pwm_ena,
  output logic          busy,
  output logic          done
);

  state_e           state_q;
  logic [N-1:0]     duty_q;
  logic [N-1:0]     target_q;
  logic [RateW-1:0] rate_q;
  logic [RateW-1:0] rate_cnt_q;
  logic             done_q;

  logic             accept;
  logic             update;
  logic [N-1:0]     duty_inc;
  logic [N-1:0]     duty_dec;
  logic [N-1:0]     duty_toward;

  tick_gen #(
    .PW(PW)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .ena   (enable),
    .period(prescale),
    .tick  (step)
  );

  assign cmd.cmd_ready = (state_q != StFade);

  always_comb begin
    accept      = cmd.cmd_valid && cmd.cmd_ready;
    update      = step && (rate_cnt_q == rate_q);
    duty_inc    = (duty_q == {N{1'b1}}) ? duty_q : duty_q + 1'b1;
    duty_dec    = (duty_q == '0) ? duty_q : duty_q - 1'b1;
    duty_toward = (target_q > duty_q) ? duty_inc : duty_dec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      duty_q     <= '0;
      target_q   <= '0;
      rate_q     <= '0;
      rate_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // An accepted command always wins over a pending rate update.
      if (accept) begin
        target_q   <= cmd.cmd_target;
        rate_q     <= cmd.cmd_rate;
        rate_cnt_q <= '0;
        unique case (cmd.cmd_mode)
          ModeOff: begin
            duty_q  <= '0;
            state_q <= StIdle;
          end
          ModeSet: begin
            duty_q  <= cmd.cmd_target;
            state_q <= StIdle;
          end
          ModeFade: begin
            if (cmd.cmd_target == duty_q) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              state_q <= StFade;
            end
          end
          ModeBreathe: begin
            duty_q  <= '0;
            state_q <= (cmd.cmd_target == '0) ? StIdle : StBrthUp;
          end
        endcase
      end else if (step) begin
        if (update) begin
          rate_cnt_q <= '0;
          unique case (state_q)
            StFade: begin
              duty_q <= duty_toward;
              if (duty_toward == target_q) begin
                state_q <= StIdle;
                done_q  <= 1'b1;
              end
            end
            StBrthUp: begin
              duty_q <= duty_inc;
              if (duty_inc == target_q) state_q <= StBrthDn;
            end
            StBrthDn: begin
              duty_q <= duty_dec;
              if (duty_dec == '0) state_q <= StBrthUp;
            end
            default: ;
          endcase
        end else begin
          rate_cnt_q <= rate_cnt_q + 1'b1;
        end
      end
    end
  end

  assign duty    = duty_q;
  assign done    = done_q;
  assign busy    = (state_q != StIdle);
  assign pwm_ena = enable && ((state_q != StIdle) || (duty_q != '0));

endmodule

// File: tb/tb_pwm_fader.sv
// Randomised and directed bench for pwm_fader against a behavioural duty/handshake model.
module tb_pwm_fader;
  import pwm_fader_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned PW = 16;
  localparam int          DMax = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic [PW-1:0] prescale = '0;
  logic          step;
  logic [N-1:0]  duty;
  logic          pwm_ena;
  logic          busy;
  logic          done;

  pwm_fader_if #(.N(N)) cmd_if ();

  pwm_fader #(
    .N (N),
    .PW(PW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .prescale(prescale),
    .cmd     (cmd_if),
    .step    (step),
    .duty    (duty),
    .pwm_ena (pwm_ena),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: activity 0 = idle, 1 = fading, 2 = breathing (m_dir is +1/-1).
  int m_duty, m_tgt, m_rate, m_nsteps, m_act, m_dir, m_k;
  bit m_tick, m_done;

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > DMax) ? DMax : v);
  endfunction

  task automatic model_reset();
    m_duty = 0; m_tgt = 0; m_rate = 0; m_nsteps = 0;
    m_act = 0; m_dir = 1; m_k = 0; m_tick = 0; m_done = 0;
  endtask

  task automatic model_edge();
    bit stp, acc;
    int t;
    stp = m_tick && enable;
    acc = cmd_if.cmd_valid && (m_act != 1);
    m_done = 0;
    if (acc) begin
      t = int'(cmd_if.cmd_target);
      m_tgt = t;
      m_rate = int'(cmd_if.cmd_rate);
      m_nsteps = 0;
      case (cmd_if.cmd_mode)
        ModeOff: begin m_duty = 0; m_act = 0; end
        ModeSet: begin m_duty = t; m_act = 0; end
        ModeFade: begin
          if (t == m_duty) begin m_done = 1; m_act = 0; end
          else m_act = 1;
        end
        default: begin m_duty = 0; m_act = (t == 0) ? 0 : 2; m_dir = 1; end
      endcase
    end else if (stp) begin
      m_nsteps++;
      if (m_nsteps == m_rate + 1) begin
        m_nsteps = 0;
        if (m_act == 1) begin
          m_duty = m_duty + ((m_tgt > m_duty) ? 1 : -1);
          if (m_duty == m_tgt) begin m_act = 0; m_done = 1; end
        end else if (m_act == 2) begin
          m_duty = clamp(m_duty + m_dir);
          if (m_dir > 0 && m_duty == m_tgt) m_dir = -1;
          else if (m_dir < 0 && m_duty == 0) m_dir = 1;
        end
      end
    end
    if (enable) begin
      m_k++;
      m_tick = (m_k % (int'(prescale) + 1)) == 0;
    end else begin
      m_k = 0;
      m_tick = 0;
    end
  endtask

  task automatic compare();
    check_eq("duty", duty, m_duty);
    check_eq("step", step, m_tick && enable);
    check_eq("busy", busy, m_act != 0);
    check_eq("done", done, m_done);
    check_eq("cmd_ready", cmd_if.cmd_ready, m_act != 1);
    check_eq("pwm_ena", pwm_ena, enable && (m_act != 0 || m_duty != 0));
  endtask

  // Inputs change only at the falling edge; outputs are checked at the next falling edge.
  task automatic cyc();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic send(input mode_e m, input int t, input int r);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_mode   = m;
    cmd_if.cmd_target = t[N-1:0];
    cmd_if.cmd_rate   = r[7:0];
    cyc();
    cmd_if.cmd_valid  = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      cyc();
      if (done) seen = 1;
    end
    check_eq("done_wait", seen, 1);
  endtask

  task automatic restart_prescale(input int p);
    enable = 1'b0;
    cyc();
    prescale = p[PW-1:0];
    enable = 1'b1;
  endtask

  initial begin
    int steps, d0, ndone, dmax, k;
    int brth [8];
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_mode   = ModeOff;
    cmd_if.cmd_target = '0;
    cmd_if.cmd_rate   = '0;
    model_reset();

    // Reset holds everything low even with enable and a zero prescale.
    enable = 1'b1;
    #22;
    check_eq("rst_duty", duty, 0);
    check_eq("rst_step", step, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pwm_ena", pwm_ena, 0);
    @(negedge clk);
    enable = 1'b0;
    prescale = 16'd3;
    rst = 1'b1;
    cyc();

    // Prescale 3: one step per 4 clocks.
    enable = 1'b1;
    steps = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (step) steps++;
    end
    check_eq("presc_steps", steps, 3);

    // Disabling mid-fade freezes duty and step.
    send(ModeFade, 6, 0);
    run(10);
    enable = 1'b0;
    d0 = int'(duty);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_eq("frz_duty", duty, d0);
      check_eq("frz_step", step, 0);
    end
    enable = 1'b1;
    wait_done(100);

    // Fade 0 -> 5 at rate 1: one LSB every 2 clocks.
    restart_prescale(0);
    send(ModeSet, 0, 0);
    send(ModeFade, 5, 1);
    ndone = 0;
    for (int j = 1; j <= 12; j++) begin
      cyc();
      check_eq("f42_duty", duty, (j / 2 > 5) ? 5 : j / 2);
      if (done) ndone++;
      if (j == 10) check_eq("f42_done", done, 1);
    end
    check_eq("f42_ndone", ndone, 1);
    check_eq("f42_ready", cmd_if.cmd_ready, 1);

    // Fade down from full scale.
    send(ModeSet, 255, 0);
    send(ModeFade, 250, 0);
    ndone = 0;
    for (int j = 1; j <= 8; j++) begin
      cyc();
      check_eq("f43_duty", duty, (255 - j < 250) ? 250 : 255 - j);
      if (done) ndone++;
    end
    check_eq("f43_ndone", ndone, 1);
    check_eq("f43_busy", busy, 0);

    // Breathe to 3, then OFF mid-sequence.
    brth = '{0, 1, 2, 3, 2, 1, 0, 1};
    send(ModeBreathe, 3, 0);
    check_eq("br_duty0", duty, brth[0]);
    for (int j = 1; j < 8; j++) begin
      cyc();
      check_eq("br_duty", duty, brth[j]);
      check_eq("br_busy", busy, 1);
    end
    send(ModeOff, 0, 0);
    check_eq("br_off_duty", duty, 0);
    check_eq("br_off_busy", busy, 0);

    // SET held during a fade is ignored until the fade completes.
    send(ModeFade, 20, 0);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_mode   = ModeSet;
    cmd_if.cmd_target = 8'd9;
    cmd_if.cmd_rate   = 8'd0;
    ndone = 0; dmax = 0; k = 0;
    while (k < 60 && !(ndone > 0 && duty == 8'd9)) begin
      cyc();
      if (done) ndone++;
      if (int'(duty) > dmax) dmax = int'(duty);
      k++;
    end
    cmd_if.cmd_valid = 1'b0;
    check_eq("hs_max", dmax, 20);
    check_eq("hs_duty", duty, 9);
    check_eq("hs_ndone", ndone, 1);

    // Asynchronous reset mid-fade at duty 7.
    send(ModeSet, 0, 0);
    send(ModeFade, 50, 0);
    k = 0;
    while (k < 40 && duty != 8'd7) begin
      cyc();
      k++;
    end
    check_eq("ar_reach7", duty, 7);
    #2 rst = 1'b0;
    #1;
    check_eq("ar_duty", duty, 0);
    check_eq("ar_done", done, 0);
    check_eq("ar_step", step, 0);
    check_eq("ar_busy", busy, 0);
    @(negedge clk);
    model_reset();
    rst = 1'b1;
    run(5);

    // Random commands, enable drops and prescale changes.
    for (int i = 0; i < 3000; i++) begin
      if (enable && $urandom_range(0, 39) == 0) begin
        enable = 1'b0;
        prescale = 16'($urandom_range(0, 2));
      end else if (!enable && $urandom_range(0, 2) == 0) begin
        enable = 1'b1;
      end
      cmd_if.cmd_valid = ($urandom_range(0, 5) == 0);
      cmd_if.cmd_mode  = mode_e'($urandom_range(0, 3));
      cmd_if.cmd_rate  = 8'($urandom_range(0, 2));
      if (cmd_if.cmd_mode == ModeBreathe)
        cmd_if.cmd_target = 8'($urandom_range(0, 5));
      else if ($urandom_range(0, 3) == 0)
        cmd_if.cmd_target = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(250, 255))
                                                        : 8'($urandom_range(0, 5));
      else
        cmd_if.cmd_target = 8'(clamp(m_duty + int'($urandom_range(0, 20)) - 10));
      cyc();
    end
    cmd_if.cmd_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pwm_fader.md
PWM_FADER -- requirements
Module: pwm_fader

Interface
REQ-001 SHALL have parameter N, default 8, meaning the duty width, which matches the width of the driven pwm.
REQ-002 SHALL have parameter PW, default 16, meaning the prescale width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-005 SHALL have port enable, input, 1 bit: global run enable.
REQ-006 SHALL have port prescale, input, PW bits: clocks per step, minus 1.
REQ-007 SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-008 SHALL have port cmd_ready, output, 1 bit: command can be accepted.
REQ-009 SHALL have port cmd_mode, input, 2 bits: 0 OFF, 1 SET, 2 FADE, 3 BREATHE.
REQ-010 SHALL have port cmd_target, input, N bits: target or peak duty.
REQ-011 SHALL have port cmd_rate, input, 8 bits: step pulses per 1-LSB duty change, minus 1.
REQ-012 SHALL have port step, output, 1 bit: one-cycle tick, driving the pwm step input.
REQ-013 SHALL have port duty, output, N bits: registered duty, driving the pwm duty input.
REQ-014 SHALL have port pwm_ena, output, 1 bit: pwm enable; equals enable AND (state != IDLE OR duty != 0).
REQ-015 SHALL have port busy, output, 1 bit: high in FADE, BRTH_UP and BRTH_DN.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse when a FADE reaches its target.

Function
REQ-017 Prescaler behaviour while enable=1:
- SHALL pulse step for 1 cycle every prescale+1 clocks.
- prescale=0 SHALL mean step is high every cycle.
REQ-018 Prescaler behaviour while enable=0: SHALL clear the prescaler count, hold step at 0, and freeze duty and the rate counter.
REQ-019 The rate counter SHALL count step pulses and issue an update when the count reaches the latched rate, then clear; rate=0 means an update on every step.
REQ-020 States SHALL be IDLE, FADE, BRTH_UP and BRTH_DN.
REQ-021 cmd_ready SHALL be 1 in IDLE, BRTH_UP and BRTH_DN, and 0 in FADE.
REQ-022 A command SHALL be accepted on a cycle where cmd_valid=1 and cmd_ready=1; target and rate are latched and the rate counter is cleared on acceptance.
REQ-023 OFF accepted: duty SHALL become 0 next cycle; state SHALL go to IDLE.
REQ-024 SET accepted: duty SHALL become cmd_target next cycle; state SHALL go to IDLE; no done pulse.
REQ-025 FADE accepted, target != duty: state SHALL go to FADE; each update SHALL move duty 1 LSB toward target.
REQ-026 FADE completion: on the cycle duty is written equal to target, done SHALL pulse on the following cycle and state SHALL return to IDLE.
REQ-027 FADE accepted with target == duty: done SHALL pulse on the next cycle; state SHALL stay IDLE.
REQ-028 BREATHE accepted, target != 0: duty SHALL be cleared to 0 and the state SHALL go to BRTH_UP.
REQ-029 BRTH_UP: each update SHALL increment duty; on reaching target the state SHALL go to BRTH_DN.
REQ-030 BRTH_DN: each update SHALL decrement duty; on reaching 0 the state SHALL go to BRTH_UP; this repeats until a new command is accepted.
REQ-031 BREATHE accepted with target == 0: SHALL behave as OFF.
REQ-032 Duty arithmetic SHALL saturate at 0 and 2^N-1 and never wrap.
REQ-033 A command accepted in a breathe state SHALL take effect the next cycle, preempting any pending update.
REQ-034 cmd_valid during FADE SHALL be ignored (held off by cmd_ready=0), not queued.

Reset
REQ-035 While rst=0 the block SHALL hold: state IDLE, duty 0, step 0, done 0, busy 0, pwm_ena 0, all counters 0, latched target 0, rate 0.
REQ-036 Reset asserted mid-FADE or mid-breathe SHALL abort immediately with no done pulse.
REQ-037 After reset release, cmd_ready SHALL be 1 on the first clock edge.

Structure
REQ-038 A shared package SHALL hold the mode enum (OFF, SET, FADE, BREATHE) and the state enum.
REQ-039 The prescaler SHALL be a sub-module, tick_gen (ports clk, rst, ena, period, tick), reusable by other blocks.
REQ-040 pwm_fader SHALL NOT instantiate the pwm; the top level connects step, duty and pwm_ena to it.

Verification
REQ-041 Prescale: prescale=3, enable=1 -> step high once every 4 clocks; enable dropped -> step 0 and duty frozen.
REQ-042 FADE 0->5: rate=1, prescale=0 -> duty steps 1..5 every 2 clocks, done pulses once, then cmd_ready=1.
REQ-043 FADE down: duty=255, FADE to 250 -> duty decrements without wrap, done asserted exactly once, busy 0 afterward.
REQ-044 BREATHE: target=3, rate=0, prescale=0 -> duty sequence 0,1,2,3,2,1,0,1 with busy=1; OFF mid-sequence -> duty 0 next cycle, state IDLE.
REQ-045 Handshake: cmd_valid held with SET 9 during FADE -> ignored until FADE done, then accepted and duty=9 next cycle.
REQ-046 Reset mid-FADE: rst low at duty=7 -> duty 0, done 0, step 0 immediately, without waiting for a clock edge.
